// File: rtl/water_led_multi.sv
// water_led_multi
//   Parametrised running-light generator for a bank of LED_NUM LEDs.
//   A prescaler advances the pattern one step every STEP_CYCLES clocks.
//   Four patterns are selectable: rotate left, rotate right, ping-pong
//   bounce and bar fill. A pause input freezes everything, and a one-cycle
//   strobe marks each pattern advance.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : synchronous reset, active low
//   enable     : 1 = run, 0 = pause (prescaler, pattern and direction hold)
//   mode       : 00 rotate left, 01 rotate right, 10 ping-pong, 11 bar fill
//   led_out    : registered LED pattern, 1 = LED on
//   step_pulse : registered strobe, high for the cycle led_out advanced
module water_led_multi #(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 25_000_000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  output logic [LED_NUM-1:0] led_out,
  output logic               step_pulse
);

  localparam int CNT_W = $clog2(STEP_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [LED_NUM-1:0] LED_INIT = LED_NUM'(1);

  logic [CNT_W-1:0]   cnt;
  logic               dir;
  logic [1:0]         mode_q;
  logic [LED_NUM-1:0] led_nxt;
  logic               dir_nxt;
  logic               wrap;

  assign wrap = (cnt == CNT_LAST);

  // Next pattern for the currently latched mode. A step is only taken when
  // mode equals mode_q, so mode_q is the mode in effect.
  always_comb begin
    led_nxt = led_out;
    dir_nxt = dir;
    unique case (mode_q)
      2'b00: led_nxt = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
      2'b01: led_nxt = {led_out[0], led_out[LED_NUM-1:1]};
      2'b10: begin
        // Direction flips on the step that lands on an end LED, so each end
        // is lit for a single step only.
        if (!dir) begin
          led_nxt = led_out << 1;
          if (led_nxt[LED_NUM-1]) dir_nxt = 1'b1;
        end else begin
          led_nxt = led_out >> 1;
          if (led_nxt[0]) dir_nxt = 1'b0;
        end
      end
      default: begin
        // Bar fill: all-ones empties the bar; otherwise shift a one in from
        // the LSB (which also turns an empty bar into 0...01).
        if (&led_out) led_nxt = '0;
        else          led_nxt = {led_out[LED_NUM-2:0], 1'b1};
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      led_out    <= LED_INIT;
      cnt        <= '0;
      dir        <= 1'b0;
      mode_q     <= 2'b00;
      step_pulse <= 1'b0;
    end else if (mode != mode_q) begin
      // Mode change reloads the pattern regardless of enable.
      led_out    <= LED_INIT;
      cnt        <= '0;
      dir        <= 1'b0;
      mode_q     <= mode;
      step_pulse <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (enable) begin
        if (wrap) begin
          cnt        <= '0;
          led_out    <= led_nxt;
          dir        <= dir_nxt;
          step_pulse <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/water_led_multi.md
# water_led_multi

Parametrised running-light generator driving a bank of `LED_NUM` LEDs. Advances one pattern step every `STEP_CYCLES` clocks and supports four patterns: rotate left, rotate right, ping-pong bounce and bar fill. It has a pause control and emits a one-cycle step strobe. It sits directly between the board clock/reset and the LED pins, and replaces the fixed 4-LED shift-only light.

## Interface

Parameters:
- `LED_NUM`, default 4: number of LEDs. Must be ≥ 2.
- `STEP_CYCLES`, default 25_000_000: clocks per pattern step. Must be ≥ 2. Prescaler width is `$clog2(STEP_CYCLES)`.

Ports:
- `clock`, input, 1: single clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-low reset.
- `enable`, input, 1: 1 = run, 0 = pause. While paused, the prescaler and pattern hold.
- `mode`, input, 2: pattern select. 00 = rotate left, 01 = rotate right, 10 = ping-pong, 11 = bar fill.
- `led_out`, output, `LED_NUM`: registered LED pattern. 1 = LED on.
- `step_pulse`, output, 1: registered strobe, high for one cycle each time `led_out` advances.

## Operation

- Registers:
  - `led_out`
  - prescaler `cnt`
  - ping-pong direction `dir` (0 = toward MSB)
  - `mode_q`, the last sampled mode
  - `step_pulse`
- Prescaler:
  - When `enable`=1, `cnt` counts 0..STEP_CYCLES-1.
  - At `cnt`==STEP_CYCLES-1, `cnt` wraps to 0 and a step occurs on that same edge.
- Mode change:
  - If `mode` != `mode_q` on an edge, then on that edge:
    - `led_out` ← 0…01
    - `cnt` ← 0
    - `dir` ← 0
    - `mode_q` ← `mode`
    - no step occurs
    - `step_pulse` ← 0
  - This takes priority over stepping and over `enable` (reload happens even while paused).
- Step rules, with P the current `led_out`:
  - 00, rotate left: P ← {P[LED_NUM-2:0], P[LED_NUM-1]}. Example: 1000 → 0001.
  - 01, rotate right: P ← {P[0], P[LED_NUM-1:1]}. Example: 0001 → 1000.
  - 10, ping-pong, one-hot:
    - If `dir`=0, shift toward MSB; on reaching bit LED_NUM-1, set `dir`=1.
    - If `dir`=1, shift toward LSB; on reaching bit 0, set `dir`=0.
    - End LEDs are lit for one step only (no double-dwell).
    - Sequence for LED_NUM=4: 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010 …
  - 11, bar fill:
    - If P is all-ones, P ← 0…00.
    - Else if P == 0, P ← 0…01.
    - Else P ← {P[LED_NUM-2:0], 1'b1}.
    - Period is LED_NUM+1 steps.
- Recovery from non-canonical states:
  - A P that is not valid for the current mode is corrected only by reset or a mode change.
  - This cannot arise in normal operation.

## Timing

- Reset (`reset`=0 at an edge) sets:
  - `led_out` = 0…01
  - `cnt` = 0
  - `dir` = 0
  - `mode_q` = 00
  - `step_pulse` = 0
- Reset overrides all other inputs.
- Reset mid-step discards the partial prescaler count.
- After reset release, if `mode` ≠ 00, the first edge performs a mode-change reload (`led_out` remains 0…01).
- With `enable` continuously 1 and no mode change:
  - The first step happens on the STEP_CYCLES-th edge after release (or after reload).
  - `led_out` then changes every STEP_CYCLES edges.
- `step_pulse` is asserted on the same edge `led_out` updates. It stays high exactly one cycle and is never high two cycles in a row.
- Pause:
  - An edge with `enable`=0 holds `cnt`, `led_out` and `dir`.
  - When `enable` returns to 1, counting resumes from the held `cnt`, so no step is lost or duplicated.
- `enable` is sampled synchronously. There is no combinational path from any input to any output.

## Test plan

All scenarios use LED_NUM=4, STEP_CYCLES=4, 10 ns clock.

- **Reset and rotate left:**
  - Stimulus: `reset`=0 for 5 cycles, then release with mode=00 and enable=1.
  - Response: `led_out`=0001 during reset. Then 0010, 0100, 1000, 0001 at edges 4, 8, 12, 16 after release. `step_pulse` is high on exactly those cycles.
- **Ping-pong bounce:**
  - Stimulus: mode=10 from reset, 8 steps.
  - Response: `led_out` sequence is 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100. Endpoints are never repeated on consecutive steps.
- **Bar fill wrap:**
  - Stimulus: mode=11, 6 steps.
  - Response: `led_out` sequence is 0011, 0111, 1111, 0000, 0001, 0011.
- **Pause:**
  - Stimulus: mode=01, enable=1 for 6 cycles, enable=0 for 10 cycles, then enable=1.
  - Response: step at edge 4 gives 1000. `led_out` holds during the pause. The next step (0100) comes exactly 2 enabled edges after resume.
- **Mode change mid-step:**
  - Stimulus: in mode=00 with `led_out`=0100 and `cnt`=2, switch mode to 10.
  - Response: next edge gives `led_out`=0001, `cnt`=0, no `step_pulse`. The following step comes 4 edges later and gives 0010.
- **Reset mid-operation:**
  - Stimulus: in mode=11 with `led_out`=0111, assert `reset`=0 for 1 cycle with enable=1.
  - Response: `led_out`=0001 and `step_pulse`=0 on that edge. If mode is still 11, the first edge after release performs a reload. The first step then occurs 4 edges after that reload and gives 0011.
